// File: rtl/vrc_pkg.sv
// Shared constants for the VRC2/VRC4 mapper: register groups, IRQ prescaler
// reload values and nametable mirroring encodings.
package vrc_pkg;

  localparam logic [2:0] REG_PRG0     = 3'd0;
  localparam logic [2:0] REG_MIRR     = 3'd1;
  localparam logic [2:0] REG_PRG1     = 3'd2;
  localparam logic [2:0] REG_CHR_BASE = 3'd3;
  localparam logic [2:0] REG_IRQ      = 3'd7;

  localparam logic [8:0] PRESCALE_RELOAD = 9'd341;
  localparam logic [8:0] PRESCALE_STEP   = 9'd3;

  localparam logic [1:0] MIRR_VERT   = 2'd0;
  localparam logic [1:0] MIRR_HORZ   = 2'd1;
  localparam logic [1:0] MIRR_ONE_LO = 2'd2;
  localparam logic [1:0] MIRR_ONE_HI = 2'd3;

endpackage

// File: rtl/vrc4_mapper_if.sv
// CPU and PPU cartridge-side bus bundle seen by the mapper.
interface vrc4_mapper_if #(
  parameter int PRG_BANK_BITS = 5,
  parameter int CHR_ADDR_BITS = 8
);
  logic                     romsel;
  logic                     cpu_rw_in;
  logic [14:0]              cpu_addr_in;
  logic [7:0]               cpu_data_in;
  logic [PRG_BANK_BITS-1:0] cpu_addr_out;
  logic                     cpu_wr_out;
  logic                     cpu_rd_out;
  logic                     cpu_flash_ce;
  logic                     cpu_sram_ce;
  logic                     ppu_rd_in;
  logic                     ppu_wr_in;
  logic [3:0]               ppu_addr_in;
  logic [CHR_ADDR_BITS-1:0] ppu_addr_out;
  logic                     ppu_rd_out;
  logic                     ppu_wr_out;
  logic                     ppu_flash_ce;
  logic                     ppu_sram_ce;
  logic                     ppu_ciram_a10;
  logic                     ppu_ciram_ce;

  modport slave (
    input  romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_rd_in, ppu_wr_in, ppu_addr_in,
    output cpu_addr_out, cpu_wr_out, cpu_rd_out, cpu_flash_ce, cpu_sram_ce,
           ppu_addr_out, ppu_rd_out, ppu_wr_out, ppu_flash_ce, ppu_sram_ce,
           ppu_ciram_a10, ppu_ciram_ce
  );

  modport master (
    output romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_rd_in, ppu_wr_in, ppu_addr_in,
    input  cpu_addr_out, cpu_wr_out, cpu_rd_out, cpu_flash_ce, cpu_sram_ce,
           ppu_addr_out, ppu_rd_out, ppu_wr_out, ppu_flash_ce, ppu_sram_ce,
           ppu_ciram_a10, ppu_ciram_ce
  );
endinterface

// File: rtl/vrc_irq.sv
// VRC4 IRQ: 8-bit reloading counter clocked per CPU cycle or per scanline
// via a 341/3 prescaler (three PPU dots per CPU cycle).
module vrc_irq
  import vrc_pkg::*;
(
  input  logic       m2,
  input  logic       reset,
  input  logic       we_latch_lo,
  input  logic       we_latch_hi,
  input  logic       we_ctrl,
  input  logic       we_ack,
  input  logic [3:0] data,
  output logic       irq_pending
);

  logic [7:0] latch;
  logic [7:0] counter;
  logic [8:0] prescaler;
  logic       en;
  logic       en_ack;
  logic       mode;
  logic       pending;
  logic       counting;
  logic       tick;

  assign counting = en & ~we_ctrl;

  always_comb begin
    tick = 1'b0;
    if (counting) tick = mode | (prescaler < PRESCALE_STEP);
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      latch     <= '0;
      counter   <= '0;
      prescaler <= PRESCALE_RELOAD;
      en        <= 1'b0;
      en_ack    <= 1'b0;
      mode      <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (we_latch_lo) latch[3:0] <= data;
      if (we_latch_hi) latch[7:4] <= data;
      if (we_ctrl) begin
        en_ack  <= data[0];
        en      <= data[1];
        mode    <= data[2];
        pending <= 1'b0;
        if (data[1]) begin
          counter   <= latch;
          prescaler <= PRESCALE_RELOAD;
        end
      end else begin
        if (we_ack) begin
          pending <= 1'b0;
          en      <= en_ack;
        end
        if (counting && !mode)
          prescaler <= (prescaler < PRESCALE_STEP) ? prescaler + (PRESCALE_RELOAD - PRESCALE_STEP)
                                                   : prescaler - PRESCALE_STEP;
        // Placed after the ack so a coinciding overflow keeps the IRQ raised.
        if (tick) begin
          if (counter == 8'hFF) begin
            counter <= latch;
            pending <= 1'b1;
          end else begin
            counter <= counter + 8'd1;
          end
        end
      end
    end
  end

  assign irq_pending = pending;

endmodule

// File: rtl/vrc4_mapper.sv
// VRC2/VRC4-family mapper: PRG/CHR banking, mirroring, WRAM select and the
// optional VRC4 IRQ, all registered on M2.
module vrc4_mapper
  import vrc_pkg::*;
#(
  parameter bit VRC4          = 1'b1,
  parameter int A0_BIT        = 1,
  parameter int A1_BIT        = 0,
  parameter int PRG_BANK_BITS = 5,
  parameter int CHR_BANK_BITS = 8,
  parameter int CHR_SHIFT     = 0
) (
  input  logic m2,
  input  logic reset,
  vrc4_mapper_if.slave bus,
  output wire  irq
);

  localparam logic [PRG_BANK_BITS-1:0] PRG_LAST  = '1;
  localparam logic [PRG_BANK_BITS-1:0] PRG_LAST2 = {{(PRG_BANK_BITS-1){1'b1}}, 1'b0};

  logic [PRG_BANK_BITS-1:0]            prg0, prg1;
  logic [1:0]                          mirr;
  logic                                swap, wram_en;
  logic [7:0][CHR_BANK_BITS-1:0]       chr;

  logic                                we;
  logic [2:0]                          grp;
  logic [1:0]                          s;
  logic [2:0]                          grp_off;
  logic [2:0]                          chr_idx;
  logic [7:0]                          chr_cur, chr_nxt8;
  logic [CHR_BANK_BITS-1:0]            chr_sel;
  logic                                irq_pending;
  logic                                unused_bits;

  assign we      = ~bus.romsel & ~bus.cpu_rw_in;
  assign grp     = bus.cpu_addr_in[14:12];
  assign s       = {bus.cpu_addr_in[A1_BIT], bus.cpu_addr_in[A0_BIT]};
  assign grp_off = grp - REG_CHR_BASE;
  assign chr_idx = {grp_off[1:0], s[1]};

  // Nibble-wise CHR update; bits above CHR_BANK_BITS fall off on store.
  assign chr_cur  = 8'(chr[chr_idx]);
  assign chr_nxt8 = s[0] ? {bus.cpu_data_in[3:0], chr_cur[3:0]}
                         : {chr_cur[7:4], bus.cpu_data_in[3:0]};

  always_ff @(posedge m2) begin
    if (reset) begin
      prg0    <= '0;
      prg1    <= '0;
      mirr    <= MIRR_VERT;
      swap    <= 1'b0;
      wram_en <= 1'b0;
      chr     <= '0;
    end else if (we) begin
      case (grp)
        REG_PRG0: prg0 <= bus.cpu_data_in[PRG_BANK_BITS-1:0];
        REG_MIRR: begin
          if (!s[1]) begin
            mirr <= bus.cpu_data_in[1:0];
          end else if (VRC4) begin
            swap    <= bus.cpu_data_in[1];
            wram_en <= bus.cpu_data_in[0];
          end
        end
        REG_PRG1: prg1 <= bus.cpu_data_in[PRG_BANK_BITS-1:0];
        REG_IRQ:  ;
        default:  chr[chr_idx] <= chr_nxt8[CHR_BANK_BITS-1:0];
      endcase
    end
  end

  always_comb begin
    bus.cpu_addr_out = PRG_LAST;
    case (bus.cpu_addr_in[14:13])
      2'b00:   bus.cpu_addr_out = swap ? PRG_LAST2 : prg0;
      2'b01:   bus.cpu_addr_out = prg1;
      2'b10:   bus.cpu_addr_out = swap ? prg0 : PRG_LAST2;
      default: bus.cpu_addr_out = PRG_LAST;
    endcase
  end

  assign bus.cpu_wr_out   = bus.cpu_rw_in;
  assign bus.cpu_rd_out   = ~bus.cpu_rw_in;
  assign bus.cpu_flash_ce = bus.romsel;
  assign bus.cpu_sram_ce  = ~(m2 & bus.romsel & bus.cpu_addr_in[14] & bus.cpu_addr_in[13]
                              & (wram_en | ~VRC4));

  assign chr_sel          = chr[bus.ppu_addr_in[2:0]];
  assign bus.ppu_addr_out = chr_sel[CHR_BANK_BITS-1:CHR_SHIFT];
  assign bus.ppu_rd_out   = bus.ppu_rd_in;
  assign bus.ppu_wr_out   = bus.ppu_wr_in;
  assign bus.ppu_flash_ce = bus.ppu_addr_in[3];
  assign bus.ppu_sram_ce  = 1'b1;
  assign bus.ppu_ciram_ce = ~bus.ppu_addr_in[3];

  always_comb begin
    bus.ppu_ciram_a10 = bus.ppu_addr_in[0];
    case (mirr)
      MIRR_VERT:   bus.ppu_ciram_a10 = bus.ppu_addr_in[0];
      MIRR_HORZ:   bus.ppu_ciram_a10 = bus.ppu_addr_in[1];
      MIRR_ONE_LO: bus.ppu_ciram_a10 = 1'b0;
      default:     bus.ppu_ciram_a10 = 1'b1;
    endcase
  end

  // VRC2 builds keep the block but never strobe it, so pending stays 0.
  logic we_irq;
  assign we_irq = we & (grp == REG_IRQ) & VRC4;

  vrc_irq u_irq (
    .m2          (m2),
    .reset       (reset),
    .we_latch_lo (we_irq & (s == 2'd0)),
    .we_latch_hi (we_irq & (s == 2'd1)),
    .we_ctrl     (we_irq & (s == 2'd2)),
    .we_ack      (we_irq & (s == 2'd3)),
    .data        (bus.cpu_data_in[3:0]),
    .irq_pending (irq_pending)
  );

  assign irq = irq_pending ? 1'b0 : 1'bz;

  assign unused_bits = ^{bus.cpu_addr_in, bus.cpu_data_in};

endmodule

// File: tb/tb_vrc4_mapper.sv
// Directed bench: a default VRC4 build and a VRC2 build with CHR_SHIFT=1
// driven from the same bus stimulus.
module tb_vrc4_mapper;

  localparam int A0 = 1;
  localparam int A1 = 0;

  logic        m2 = 1'b0;
  logic        reset;
  logic        romsel, cpu_rw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic [3:0]  ppu_addr;
  wire         irq_a, irq_b;
  int          total = 0;
  int          passed = 0;

  always #5 m2 = ~m2;

  pullup (irq_a);
  pullup (irq_b);

  vrc4_mapper_if #(.PRG_BANK_BITS(5), .CHR_ADDR_BITS(8)) bus_a ();
  vrc4_mapper_if #(.PRG_BANK_BITS(5), .CHR_ADDR_BITS(7)) bus_b ();

  assign bus_a.romsel = romsel;    assign bus_b.romsel = romsel;
  assign bus_a.cpu_rw_in = cpu_rw; assign bus_b.cpu_rw_in = cpu_rw;
  assign bus_a.cpu_addr_in = cpu_addr; assign bus_b.cpu_addr_in = cpu_addr;
  assign bus_a.cpu_data_in = cpu_data; assign bus_b.cpu_data_in = cpu_data;
  assign bus_a.ppu_addr_in = ppu_addr; assign bus_b.ppu_addr_in = ppu_addr;
  assign bus_a.ppu_rd_in = 1'b1;   assign bus_b.ppu_rd_in = 1'b1;
  assign bus_a.ppu_wr_in = 1'b0;   assign bus_b.ppu_wr_in = 1'b0;

  vrc4_mapper #(.VRC4(1'b1), .A0_BIT(A0), .A1_BIT(A1), .PRG_BANK_BITS(5),
                .CHR_BANK_BITS(8), .CHR_SHIFT(0))
    dut_a (.m2(m2), .reset(reset), .bus(bus_a), .irq(irq_a));

  vrc4_mapper #(.VRC4(1'b0), .A0_BIT(A0), .A1_BIT(A1), .PRG_BANK_BITS(5),
                .CHR_BANK_BITS(8), .CHR_SHIFT(1))
    dut_b (.m2(m2), .reset(reset), .bus(bus_b), .irq(irq_b));

  function automatic logic [14:0] ra(input logic [2:0] g, input logic [1:0] s);
    logic [14:0] a;
    a = {g, 12'h000};
    a[A0] = s[0];
    a[A1] = s[1];
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] g, input logic [1:0] s, input logic [7:0] d);
    @(negedge m2);
    romsel = 1'b0; cpu_rw = 1'b0; cpu_addr = ra(g, s); cpu_data = d;
    @(posedge m2);
    #1;
    romsel = 1'b1; cpu_rw = 1'b1;
  endtask

  task automatic rd(input logic [14:0] a);
    @(negedge m2);
    romsel = 1'b0; cpu_rw = 1'b1; cpu_addr = a;
    #1;
  endtask

  initial begin
    logic [3:0] mexp;
    mexp = 4'b1010;
    reset = 1'b1; romsel = 1'b1; cpu_rw = 1'b1;
    cpu_addr = '0; cpu_data = '0; ppu_addr = '0;
    repeat (3) @(posedge m2);
    @(negedge m2) reset = 1'b0;

    rd(15'h6000); chk("rst_prg_E000", bus_a.cpu_addr_out, 5'h1F);
    rd(15'h4000); chk("rst_prg_C000", bus_a.cpu_addr_out, 5'h1E);
    chk("rst_irq", irq_a, 1'b1);
    chk("rst_chr", bus_a.ppu_addr_out, 8'h00);
    chk("rd_strobe", bus_a.cpu_rd_out, 1'b0);

    wr(3'd0, 2'd0, 8'h05);
    wr(3'd2, 2'd0, 8'h0A);
    rd(15'h0000); chk("prg0", bus_a.cpu_addr_out, 5'h05);
    chk("prg0_vrc2", bus_b.cpu_addr_out, 5'h05);
    rd(15'h2000); chk("prg1", bus_a.cpu_addr_out, 5'h0A);

    wr(3'd1, 2'd2, 8'h02);
    rd(15'h4000); chk("swap_C000", bus_a.cpu_addr_out, 5'h05);
    chk("noswap_vrc2", bus_b.cpu_addr_out, 5'h1E);
    rd(15'h0000); chk("swap_8000", bus_a.cpu_addr_out, 5'h1E);
    rd(15'h6000); chk("swap_E000", bus_a.cpu_addr_out, 5'h1F);

    wr(3'd3, 2'd0, 8'h03);
    wr(3'd3, 2'd1, 8'h0A);
    ppu_addr = 4'b0000; #1;
    chk("chr0", bus_a.ppu_addr_out, 8'hA3);
    chk("chr0_shift", bus_b.ppu_addr_out, 7'h51);
    wr(3'd6, 2'd2, 8'h04);
    wr(3'd6, 2'd3, 8'h0C);
    ppu_addr = 4'b0111; #1;
    chk("chr7", bus_a.ppu_addr_out, 8'hC4);
    chk("chr7_shift", bus_b.ppu_addr_out, 7'h62);
    ppu_addr = 4'b1000; #1;
    chk("ppu_flash_ce", bus_a.ppu_flash_ce, 1'b1);
    chk("ciram_ce", bus_a.ppu_ciram_ce, 1'b0);

    ppu_addr = 4'b0010;
    for (int m = 0; m < 4; m++) begin
      wr(3'd1, 2'd0, 8'(m));
      chk("mirror", bus_a.ppu_ciram_a10, mexp[m]);
    end

    @(negedge m2);
    romsel = 1'b1; cpu_rw = 1'b1; cpu_addr = 15'h6000;
    @(posedge m2); #1;
    chk("sram_off", bus_a.cpu_sram_ce, 1'b1);
    chk("sram_vrc2", bus_b.cpu_sram_ce, 1'b0);
    wr(3'd1, 2'd3, 8'h01);
    cpu_addr = 15'h6000; #1;
    chk("sram_on", bus_a.cpu_sram_ce, 1'b0);
    @(negedge m2); #1;
    chk("sram_m2_low", bus_a.cpu_sram_ce, 1'b1);

    // Cycle mode: $FE reaches $FF then overflows on the second edge.
    wr(3'd7, 2'd0, 8'h0E);
    wr(3'd7, 2'd1, 8'h0F);
    wr(3'd7, 2'd2, 8'h07);
    @(posedge m2); #1; chk("cyc_1", irq_a, 1'b1);
    @(posedge m2); #1; chk("cyc_2", irq_a, 1'b0);
    chk("cyc_vrc2", irq_b, 1'b1);
    wr(3'd7, 2'd3, 8'h00);
    chk("ack_clear", irq_a, 1'b1);
    @(posedge m2); #1; chk("cyc_again", irq_a, 1'b0);
    wr(3'd7, 2'd2, 8'h00);
    chk("ctrl_clear", irq_a, 1'b1);

    wr(3'd7, 2'd0, 8'h0F);
    wr(3'd7, 2'd1, 8'h0F);
    wr(3'd7, 2'd2, 8'h02);
    repeat (113) @(posedge m2);
    #1; chk("scan_113", irq_a, 1'b1);
    @(posedge m2); #1; chk("scan_114", irq_a, 1'b0);
    chk("scan_vrc2", irq_b, 1'b1);

    @(negedge m2) reset = 1'b1;
    @(posedge m2); #1; chk("reset_irq", irq_a, 1'b1);
    @(negedge m2) reset = 1'b0;
    rd(15'h0000); chk("reset_prg", bus_a.cpu_addr_out, 5'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vrc4_mapper.md
Name: vrc4_mapper

Overview:
- Parametrised VRC2/VRC4-family mapper for the cartridge CPLD. Sits between the NES CPU/PPU buses and the PRG/CHR flash, PRG SRAM and CIRAM.
- Generalises the VRC2a mapper in four ways: configurable register-select address lines, configurable PRG/CHR bank widths, PRG swap mode and an 8-bit IRQ counter with a scanline prescaler.
- All register writes are synchronous to m2.

Parameters:
- VRC4, 1: 1 enables the IRQ block, PRG swap mode and the WRAM enable bit. 0 gives VRC2 behaviour: no IRQ, no swap, WRAM always enabled.
- A0_BIT, 1: cpu_addr_in bit used as register sub-address bit 0.
- A1_BIT, 0: cpu_addr_in bit used as register sub-address bit 1.
- PRG_BANK_BITS, 5: width of the PRG 8 KB bank registers.
- CHR_BANK_BITS, 8: width of the CHR 1 KB bank registers.
- CHR_SHIFT, 0: 1 right-shifts the CHR bank by one bit (VRC2a CHR wiring).

Ports:
- m2, input, 1: CPU M2. This is the single block clock.
- reset, input, 1: synchronous, active-high reset.
- romsel, input, 1: /ROMSEL, active low.
- cpu_rw_in, input, 1: CPU R/W (1 = read).
- cpu_addr_in, input, 15: CPU A14..A0.
- cpu_data_in, input, 8: CPU data bus.
- cpu_addr_out, output, PRG_BANK_BITS: PRG flash A13 and up.
- cpu_wr_out, output, 1: equals cpu_rw_in.
- cpu_rd_out, output, 1: equals ~cpu_rw_in.
- cpu_flash_ce, output, 1: equals romsel.
- cpu_sram_ce, output, 1: active-low PRG SRAM select.
- ppu_rd_in, input, 1: PPU /RD.
- ppu_wr_in, input, 1: PPU /WR.
- ppu_addr_in, input, 4: PPU A13..A10.
- ppu_addr_out, output, CHR_BANK_BITS-CHR_SHIFT: CHR A10 and up.
- ppu_rd_out, ppu_wr_out, output, 1 each: pass-through of ppu_rd_in and ppu_wr_in.
- ppu_flash_ce, output, 1: equals ppu_addr_in[13].
- ppu_sram_ce, output, 1: tied to 1.
- ppu_ciram_a10, output, 1: CIRAM A10.
- ppu_ciram_ce, output, 1: equals ~ppu_addr_in[13].
- irq, output, 1: open-drain. Drives 0 while IRQ is pending, Z otherwise.

Behaviour:
- Clock and reset: one clock, m2. Reset is synchronous and active-high.
- Write strobe (we): romsel==0 and cpu_rw_in==0, sampled at posedge m2. The board guarantees address and data are stable at that edge.
  - The register is selected by cpu_addr_in[14:12] plus the sub-address s = {cpu_addr_in[A1_BIT], cpu_addr_in[A0_BIT]}.
  - Register contents update on that edge.
- Register map (CPU address, s):
  - $8xxx: prg0 = data[PRG_BANK_BITS-1:0].
  - $9xxx, s=0 or 1: mirr = data[1:0].
  - $9xxx, s=2 or 3, VRC4 only: swap = data[1], wram_en = data[0].
  - $Axxx: prg1.
  - $B000-$E003: CHR bank n = 2*(A[14:12]-3) + s[1].
    - s[0]=0 writes bank n low nibble; s[0]=1 writes bank n high nibble (bits beyond CHR_BANK_BITS are dropped).
  - $F, s=0: latch[3:0]. s=1: latch[7:4]. s=2: IRQ control. s=3: IRQ ack.
  - $F writes are ignored when VRC4=0.
- PRG mapping, selected by A14:A13 (N = all ones):
  - swap=0: 00 -> prg0, 01 -> prg1, 10 -> N-1, 11 -> N.
  - swap=1: 00 -> N-1, 01 -> prg1, 10 -> prg0, 11 -> N.
  - Combinational.
- cpu_sram_ce = ~(m2 & romsel & A14 & A13 & (wram_en | ~VRC4)).
- CHR: ppu_addr_out = chr[ppu_addr_in[12:10]] >> CHR_SHIFT. Combinational.
- Mirroring (mirr):
  - 0: ppu_ciram_a10 = A10.
  - 1: A11.
  - 2: 0.
  - 3: 1.
- IRQ state:
  - Registers: latch (8 bits), counter (8 bits), prescaler (9 bits, range 0..340), E, A, M, pending.
- Control write ($F, s=2):
  - A = d0, E = d1, M = d2; pending <= 0.
  - If d1=1: counter <= latch and prescaler <= 341.
- Ack write ($F, s=3): pending <= 0, E <= A.
- Counter clocking, every m2 cycle while E=1 and not during a control write:
  - M=1 (cycle mode): tick every cycle.
  - M=0 (scanline mode): if prescaler < 3, then prescaler += 338 and tick; else prescaler -= 3.
- Tick: if counter==$FF, counter <= latch and pending <= 1; else counter += 1.
  - A tick coinciding with an ack write: the tick's pending=1 wins.
- Reset:
  - All bank registers, mirr, swap, wram_en, latch, counter, E, A, M and pending are 0.
  - prescaler = 341; irq is Z.
  - Reset asserted mid-count clears pending on the next edge.

Decomposition:
- Package vrc_pkg: register-group constants (REG_PRG0=0, REG_MIRR=1, REG_PRG1=2, REG_IRQ=7), PRESCALE_RELOAD=341, PRESCALE_STEP=3, and the mirroring encodings.
- Sub-module vrc_irq: latch, counter, prescaler and E/A/M/pending. Interface: m2, reset, we_latch_lo, we_latch_hi, we_ctrl, we_ack, data[3:0] and data[2:0], irq_pending.

Test Plan:
- Reset then read $E000 -> cpu_addr_out = all ones. $C000 -> all ones minus 1. irq = Z. ppu_addr_out = 0.
- Write $8000=$05 and $A000=$0A, then read $8000 and $A000 -> 5 and 10. Write $9002=$02, then read $C000 -> 5 and $8000 -> N-1.
- Write $B000=$3 and $B001=$A, then PPU A12:10=0 -> ppu_addr_out=$A3. With CHR_SHIFT=1 -> $51.
- Mirroring: $9000=0, 1, 2, 3 with PPU A11=1, A10=0 -> ciram_a10 = 0, 1, 0, 1.
- Cycle mode: latch=$FE, control=$07 -> irq driven low exactly 2 m2 cycles after the control write. Then ack -> irq Z and E stays 1 (A=1). The next assertion follows after 2 more cycles.
- Scanline mode: latch=$FF, control=$02 -> first tick after 114 cycles, so irq low at cycle 114. A VRC4=0 build ignores $F002 and irq stays Z.
